// File: rtl/ram_16x8.sv
// Single-port synchronous RAM in flip-flops so async reset can clear every word.
// Writes pass din straight to dout; reads return the addressed word one edge later.
module ram_16x8 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array: cleared on reset, only the addressed word changes on a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= din;
    end
  end

  // Registered read port with write-through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (we) begin
      dout <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_16x8.sv
// Directed self-checking bench for ram_16x8.
// Inputs change 1 time unit after a rising edge; dout is sampled 1 unit after the next edge.
module tb_ram_16x8;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;

  ram_16x8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation, clock it, then compare dout with the expected value
  task automatic cyc(input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] exp, input string name);
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h expected=%h", name, a, dout, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%h expected=00", dout);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_held got=%h expected=00", dout);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'(i), 8'h00, 8'h00, "reset_read");
  endtask

  task automatic test_write_read();
    cyc(1'b1, 4'd4, 8'hA5, 8'hA5, "write_through");
    cyc(1'b0, 4'd4, 8'h00, 8'hA5, "read_after_write");
  endtask

  task automatic test_isolation();
    cyc(1'b1, 4'd3,  8'h11, 8'h11, "iso_wr3");
    cyc(1'b1, 4'd5,  8'h22, 8'h22, "iso_wr5");
    cyc(1'b1, 4'd15, 8'hFF, 8'hFF, "iso_wr15");
    cyc(1'b1, 4'd0,  8'h01, 8'h01, "iso_wr0");
    cyc(1'b1, 4'd4,  8'h00, 8'h00, "iso_wr4");
    cyc(1'b0, 4'd3,  8'h5A, 8'h11, "iso_rd3");
    cyc(1'b0, 4'd5,  8'h5A, 8'h22, "iso_rd5");
    cyc(1'b0, 4'd15, 8'h5A, 8'hFF, "iso_rd15");
    cyc(1'b0, 4'd0,  8'h5A, 8'h01, "iso_rd0");
    cyc(1'b0, 4'd4,  8'h5A, 8'h00, "iso_rd4");
    cyc(1'b0, 4'd1,  8'h5A, 8'h00, "iso_rd1");
  endtask

  task automatic test_overwrite();
    cyc(1'b1, 4'd7, 8'h3C, 8'h3C, "ovw_first");
    cyc(1'b1, 4'd7, 8'hC3, 8'hC3, "ovw_second");
    cyc(1'b0, 4'd7, 8'h00, 8'hC3, "ovw_read");
    cyc(1'b0, 4'd3, 8'h00, 8'h11, "ovw_neighbour");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 8'h80 + 8'(i), 8'h80 + 8'(i), "fill");
    cyc(1'b0, 4'd9, 8'h00, 8'h89, "fill_read9");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL async_clear got=%h expected=00", dout);
    end
    cyc(1'b1, 4'd2, 8'hEE, 8'h00, "reset_no_write");
    cyc(1'b0, 4'd2, 8'hEE, 8'h00, "reset_no_read");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'(i), 8'h00, 8'h00, "post_reset_read");
  endtask

  task automatic test_hold();
    cyc(1'b1, 4'd6, 8'h66, 8'h66, "hold_wr6");
    cyc(1'b1, 4'd9, 8'h99, 8'h99, "hold_wr9");
    cyc(1'b0, 4'd6, 8'h00, 8'h66, "hold_rd6");
    #1;
    addr = 4'd9;
    din  = 8'h77;
    #2;
    checks++;
    if (dout !== 8'h66) begin
      errors++;
      $display("FAIL hold_between_edges got=%h expected=66", dout);
    end
    addr = 4'd6;
    #1;
    addr = 4'd9;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 8'h99) begin
      errors++;
      $display("FAIL hold_sampled_addr got=%h expected=99", dout);
    end
    cyc(1'b0, 4'd6, 8'h00, 8'h66, "hold_rd6_again");
    cyc(1'b0, 4'd0, 8'h00, 8'h00, "hold_addr0_cleared");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_isolation();
    test_overwrite();
    test_async_reset();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
